// File: rtl/alu_cmd_sequencer.sv
// Command-port front end for TotalALU: issues ops, times MULTU, auto-issues MFHI/MFLO,
// and returns one response (two for MULTU: Hi then Lo) on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int DATA_W     = 32,
    parameter int ALU_LAT    = 1,
    parameter int MUL_CYCLES = 33,
    parameter int MUL_SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              alu_rst,
    output logic [5:0]        alu_signal,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    input  logic [DATA_W-1:0] alu_output,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err
);

    // state      | meaning
    // S_IDLE     | ready for a command (once alu_rst has dropped)
    // S_EXEC     | single-cycle op issued, waiting ALU_LAT
    // S_MUL_WAIT | MULTU held for MUL_CYCLES+MUL_SETTLE
    // S_MFHI     | MFHI issued, waiting ALU_LAT
    // S_RSP_HI   | Hi response offered, waiting handshake
    // S_MFLO     | MFLO issued, waiting ALU_LAT
    // S_RSP      | final response offered, waiting handshake
    // S_ERR      | illegal op, build error response
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MUL_WAIT, S_MFHI, S_RSP_HI, S_MFLO, S_RSP, S_ERR
    } state_t;

    localparam int CNT_W = $clog2(MUL_CYCLES + MUL_SETTLE + ALU_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES + MUL_SETTLE - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                alu_rst_q;
    logic [5:0]          sig_q, sig_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_err_q, rsp_err_d;

    assign cmd_ready  = (state_q == S_IDLE) && !alu_rst_q;
    assign alu_rst    = alu_rst_q;
    assign alu_signal = sig_q;
    assign alu_dataA  = a_q;
    assign alu_dataB  = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_d       = sig_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    unique case (cmd_op)
                        OP_SLL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                            sig_d   = cmd_op;
                            a_d     = cmd_a;
                            b_d     = cmd_b;
                            cnt_d   = LAT_LOAD;
                            state_d = S_EXEC;
                        end
                        OP_MULTU: begin
                            sig_d   = cmd_op;
                            a_d     = cmd_a;
                            b_d     = cmd_b;
                            cnt_d   = MUL_LOAD;
                            state_d = S_MUL_WAIT;
                        end
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_output;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    sig_d   = OP_MFHI;
                    cnt_d   = LAT_LOAD;
                    state_d = S_MFHI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MFHI: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_output;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RSP_HI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RSP_HI: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    sig_d       = OP_MFLO;
                    cnt_d       = LAT_LOAD;
                    state_d     = S_MFLO;
                end
            end
            S_MFLO: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_output;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ERR: begin
                rsp_data_d  = '0;
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // alu_rst is held by reset and released on the first edge afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_rst_q   <= 1'b1;
            sig_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_rst_q   <= 1'b0;
            sig_q       <= sig_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural TotalALU that only updates
// Hi/Lo once MULTU has been held for MUL_CYCLES consecutive cycles.
module tb_alu_cmd_sequencer;

    localparam int DATA_W     = 32;
    localparam int MUL_CYCLES = 33;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [5:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              alu_rst;
    logic [5:0]        alu_signal;
    logic [DATA_W-1:0] alu_dataA;
    logic [DATA_W-1:0] alu_dataB;
    logic [DATA_W-1:0] alu_output;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    int checks = 0;
    int failures = 0;

    alu_cmd_sequencer #(.DATA_W(DATA_W), .ALU_LAT(1), .MUL_CYCLES(MUL_CYCLES), .MUL_SETTLE(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_rst(alu_rst), .alu_signal(alu_signal),
        .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_output(alu_output),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TotalALU model: ALU ops combinational, Hi/Lo written after MUL_CYCLES of MULTU.
    logic [DATA_W-1:0] hi_m, lo_m;
    int                mul_cnt;
    always @(posedge clk) begin
        if (alu_rst) begin
            hi_m    <= '0;
            lo_m    <= '0;
            mul_cnt <= 0;
        end else if (alu_signal == 6'd25) begin
            if (mul_cnt == MUL_CYCLES - 1) {hi_m, lo_m} <= alu_dataA * alu_dataB;
            mul_cnt <= mul_cnt + 1;
        end else begin
            mul_cnt <= 0;
        end
    end

    always_comb begin
        alu_output = '0;
        case (alu_signal)
            6'd36: alu_output = alu_dataA & alu_dataB;
            6'd37: alu_output = alu_dataA | alu_dataB;
            6'd32: alu_output = alu_dataA + alu_dataB;
            6'd34: alu_output = alu_dataA - alu_dataB;
            6'd42: alu_output = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            6'd0:  alu_output = alu_dataA << alu_dataB[4:0];
            6'd16: alu_output = hi_m;
            6'd18: alu_output = lo_m;
            default: alu_output = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [5:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        int cyc;
        send_cmd(op, a, b);
        chk({tag, "_sig"}, 32'(alu_signal), 32'(op));
        wait_rsp(10, cyc);
        chk({tag, "_lat"}, cyc, 1);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_last"}, 32'(rsp_last), 1);
        chk({tag, "_err"}, 32'(rsp_err), 0);
        take_rsp();
        chk({tag, "_idle"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    initial begin
        int cyc, sig16_cyc;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_rst", 32'(alu_rst), 1);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_last, rsp_err}, 0);
        chk("rst_alu_sig", 32'(alu_signal), 0);
        chk("rst_alu_a", alu_dataA, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_alu_rst", 32'(alu_rst), 0);
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        run_single("add", 6'd32, 32'd5, 32'd7, 32'd12);
        run_single("sub", 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_single("slt", 6'd42, 32'd3, 32'd5, 32'd1);
        run_single("sll", 6'd0, 32'd1, 32'd4, 32'd16);
        run_single("and", 6'd36, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        run_single("or", 6'd37, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);

        // MULTU: MFHI issue at T0+35, Hi at T0+36
        send_cmd(6'd25, 32'hFFFF_FFFF, 32'd2);
        chk("mul_sig25", 32'(alu_signal), 25);
        sig16_cyc = -1;
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (alu_signal == 6'd16 && sig16_cyc < 0) sig16_cyc = i;
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        chk("mul_mfhi_cyc", sig16_cyc, 35);
        chk("mul_hi_cyc", cyc, 36);
        chk("mul_hi_data", rsp_data, 32'd1);
        chk("mul_hi_last", 32'(rsp_last), 0);
        chk("mul_opa_held", alu_dataA, 32'hFFFF_FFFF);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 6'd32;
        cmd_a     = 32'd9;
        cmd_b     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_data", rsp_data, 32'd1);
            chk("hold_sig", 32'(alu_signal), 16);
            chk("hold_flags", {29'd0, rsp_valid, rsp_last, cmd_ready}, 32'b100);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("mul_sig18", 32'(alu_signal), 18);
        chk("mul_hi_taken", 32'(rsp_valid), 0);
        wait_rsp(10, cyc);
        chk("mul_lo_lat", cyc, 1);
        chk("mul_lo_data", rsp_data, 32'hFFFF_FFFE);
        chk("mul_lo_last", 32'(rsp_last), 1);
        take_rsp();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("mul_no_extra", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        end
        chk("idle_sig18", 32'(alu_signal), 18);

        // illegal op
        send_cmd(6'd7, 32'd11, 32'd22);
        wait_rsp(5, cyc);
        chk("err_lat", cyc, 1);
        chk("err_data", rsp_data, 0);
        chk("err_flags", {30'd0, rsp_err, rsp_last}, 32'b11);
        chk("err_sig", 32'(alu_signal), 18);
        chk("err_opa", alu_dataA, 32'hFFFF_FFFF);
        take_rsp();
        chk("err_clear", 32'(rsp_err), 0);

        // reset in the middle of a MULTU
        send_cmd(6'd25, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_sig25", 32'(alu_signal), 25);
        reset = 1'b0;
        #1;
        chk("mid_alu_rst", 32'(alu_rst), 1);
        chk("mid_sig", 32'(alu_signal), 0);
        chk("mid_ops", alu_dataA | alu_dataB, 0);
        chk("mid_rsp", {28'd0, rsp_valid, rsp_last, rsp_err, cmd_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel", {30'd0, alu_rst, cmd_ready}, 32'b01);
        chk("mid_no_rsp", 32'(rsp_valid), 0);
        run_single("add2", 6'd32, 32'd1, 32'd1, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
